ct_spsram_gen: RTL and testbench



---
 rtl/ct_spsram_gen_if.sv | 34 +++
 rtl/ct_spsram_gen.sv | 134 +++++++++++++
 tb/tb_ct_spsram_gen.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/ct_spsram_gen_if.sv
// ct_spsram_gen_if: access bus of the parametrised single-port SRAM wrapper.
//   A         - access address
//   CEN       - chip enable, active-low
//   GWEN      - global write enable, active-low (0 = write, 1 = read)
//   WEN       - per-group write enable, active-low
//   D         - write data
//   Q         - read data
//   Q_VLD     - one-cycle strobe marking a new read result on Q
//   INIT_BUSY - high while the post-reset init sweep runs
// master: the requester driving accesses; slave: the SRAM wrapper.
interface ct_spsram_gen_if #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 144,
    parameter int unsigned WE_WIDTH   = 144
);
    logic [ADDR_WIDTH-1:0] A;
    logic                  CEN;
    logic                  GWEN;
    logic [WE_WIDTH-1:0]   WEN;
    logic [DATA_WIDTH-1:0] D;
    logic [DATA_WIDTH-1:0] Q;
    logic                  Q_VLD;
    logic                  INIT_BUSY;

    modport master (
        output A, CEN, GWEN, WEN, D,
        input  Q, Q_VLD, INIT_BUSY
    );

    modport slave (
        input  A, CEN, GWEN, WEN, D,
        output Q, Q_VLD, INIT_BUSY
    );
endinterface

// File: rtl/ct_spsram_gen.sv
// ct_spsram_gen: parametrised single-port SRAM wrapper.
// Behavioural storage array (infers block RAM) with per-group write enables,
// optional output register stage, read-valid strobe and a post-reset sweep
// that fills every entry with INIT_VAL.
//   CLK - clock, all state updates on the rising edge
//   RST - synchronous active-high reset; restarts the init sweep
//   bus - ct_spsram_gen_if.slave (A, CEN, GWEN, WEN, D in; Q, Q_VLD, INIT_BUSY out)
// Read latency is 1 edge (OUT_REG=0) or 2 edges (OUT_REG=1).
// WE_WIDTH must divide DATA_WIDTH; WEN bit g covers D[g*G +: G].
module ct_spsram_gen #(
    parameter int unsigned           ADDR_WIDTH = 10,
    parameter int unsigned           DATA_WIDTH = 144,
    parameter int unsigned           WE_WIDTH   = 144,
    parameter bit                    OUT_REG    = 1'b0,
    parameter logic [DATA_WIDTH-1:0] INIT_VAL   = '0
) (
    input logic            CLK,
    input logic            RST,
    ct_spsram_gen_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned G     = DATA_WIDTH / WE_WIDTH;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] icnt;
    logic                  init_busy;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic                  init_wr;
    logic                  rd_acc;
    logic                  wr_acc;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [WE_WIDTH-1:0]   wgrp;

    logic [DATA_WIDTH-1:0] q;
    logic                  q_vld;

    // RST gates every access so a reset edge never touches the array.
    always_comb begin
        init_wr = !RST && (state == ST_INIT);
        rd_acc  = !RST && (state == ST_READY) && !bus.CEN && bus.GWEN;
        wr_acc  = !RST && (state == ST_READY) && !bus.CEN && !bus.GWEN;
        waddr   = bus.A;
        wdata   = bus.D;
        wgrp    = '0;
        if (init_wr) begin
            waddr = icnt;
            wdata = INIT_VAL;
            wgrp  = '1;
        end else if (wr_acc) begin
            wgrp = ~bus.WEN;
        end
    end

    // Init sweep: one entry per edge, leaves INIT on the edge writing the last entry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_INIT;
            icnt      <= '0;
            init_busy <= 1'b1;
        end else begin
            case (state)
                ST_INIT: begin
                    icnt <= icnt + 1'b1;
                    if (icnt == '1) begin
                        state     <= ST_READY;
                        init_busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Storage is not reset; contents are only replaced by the sweep.
    always_ff @(posedge CLK) begin
        for (int unsigned g = 0; g < WE_WIDTH; g++) begin
            if (wgrp[g]) begin
                mem[waddr][g*G +: G] <= wdata[g*G +: G];
            end
        end
    end

    generate
        if (OUT_REG) begin : g_out_reg
            logic [DATA_WIDTH-1:0] rd_data;
            logic                  rd_vld;

            always_ff @(posedge CLK) begin
                if (rd_acc) begin
                    rd_data <= mem[bus.A];
                end
            end

            // A reset drops the read held in the first stage.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    rd_vld <= 1'b0;
                    q      <= '0;
                    q_vld  <= 1'b0;
                end else begin
                    rd_vld <= rd_acc;
                    q_vld  <= rd_vld;
                    if (rd_vld) begin
                        q <= rd_data;
                    end
                end
            end
        end else begin : g_no_out_reg
            always_ff @(posedge CLK) begin
                if (RST) begin
                    q     <= '0;
                    q_vld <= 1'b0;
                end else begin
                    q_vld <= rd_acc;
                    if (rd_acc) begin
                        q <= mem[bus.A];
                    end
                end
            end
        end
    endgenerate

    assign bus.Q         = q;
    assign bus.Q_VLD     = q_vld;
    assign bus.INIT_BUSY = init_busy;
endmodule

// File: tb/tb_ct_spsram_gen.sv
// tb_ct_spsram_gen: directed, table-driven bench for ct_spsram_gen.
// Two instances (OUT_REG=0 and OUT_REG=1) share one stimulus stream so
// both read latencies are checked against the same expected data.
module tb_ct_spsram_gen;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 144;
    localparam int unsigned WW = 18;

    localparam logic [DW-1:0] IV    = {18{8'hA5}};
    localparam logic [DW-1:0] ONES  = {DW{1'b1}};
    localparam logic [DW-1:0] FF00  = {{(DW-8){1'b1}}, 8'h00};
    localparam logic [DW-1:0] W1234 = 144'h1234;
    localparam logic [DW-1:0] PART  = {IV[DW-1:32], 32'h11223344};

    logic clk;
    logic rst;
    logic [AW-1:0] a;
    logic cen;
    logic gwen;
    logic [WW-1:0] wen;
    logic [DW-1:0] d;

    int checks = 0;
    int errors = 0;

    ct_spsram_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW)) bus0 ();
    ct_spsram_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW)) bus1 ();

    assign bus0.A = a;  assign bus0.CEN = cen;  assign bus0.GWEN = gwen;
    assign bus0.WEN = wen;  assign bus0.D = d;
    assign bus1.A = a;  assign bus1.CEN = cen;  assign bus1.GWEN = gwen;
    assign bus1.WEN = wen;  assign bus1.D = d;

    ct_spsram_gen #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW), .OUT_REG(1'b0), .INIT_VAL(IV)
    ) u0 (
        .CLK(clk), .RST(rst), .bus(bus0)
    );

    ct_spsram_gen #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WE_WIDTH(WW), .OUT_REG(1'b1), .INIT_VAL(IV)
    ) u1 (
        .CLK(clk), .RST(rst), .bus(bus1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic          cen;
        logic          gwen;
        logic [AW-1:0] a;
        logic [WW-1:0] wen;
        logic [DW-1:0] d;
        logic          v0;
        logic [DW-1:0] q0;
        logic          v1;
        logic [DW-1:0] q1;
        string         name;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        cen = 1'b1; gwen = 1'b1; wen = '1; d = '0; a = '0;
    endtask

    // Counts cycles with INIT_BUSY high starting right after the reset edge.
    task automatic init_wait(output int n);
        n = 0;
        while (bus0.INIT_BUSY === 1'b1 && n < 40) begin
            n++;
            chk("init_q0", bus0.Q, '0);
            chk("init_vld0", DW'(bus0.Q_VLD), '0);
            chk("init_q1", bus1.Q, '0);
            chk("init_vld1", DW'(bus1.Q_VLD), '0);
            tick();
        end
    endtask

    // Streams reads of every address, expecting INIT_VAL on both instances.
    task automatic read_sweep();
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) begin
                cen = 1'b0; gwen = 1'b1; a = AW'(i);
            end else begin
                set_idle();
            end
            tick();
            if (i < 16) begin
                chk("sweep_q0", bus0.Q, IV);
                chk("sweep_vld0", DW'(bus0.Q_VLD), DW'(1));
            end else begin
                chk("sweep_end_vld0", DW'(bus0.Q_VLD), '0);
            end
            if (i > 0) begin
                chk("sweep_q1", bus1.Q, IV);
                chk("sweep_vld1", DW'(bus1.Q_VLD), DW'(1));
            end
        end
    endtask

    function automatic logic [DW-1:0] sv(input int j);
        return DW'(32'h1000 + j);
    endfunction

    initial begin
        int n;

        vecs[0]  = '{1'b0, 1'b0, 4'd3, 18'h00000, ONES,  1'b0, IV,    1'b0, IV,    "wr_full"};
        vecs[1]  = '{1'b0, 1'b0, 4'd3, 18'h3FFFE, '0,    1'b0, IV,    1'b0, IV,    "wr_grp0"};
        vecs[2]  = '{1'b0, 1'b1, 4'd3, 18'h3FFFF, '0,    1'b1, FF00,  1'b0, IV,    "rd_part"};
        vecs[3]  = '{1'b0, 1'b0, 4'd7, 18'h00000, W1234, 1'b0, FF00,  1'b1, FF00,  "wr_1234"};
        vecs[4]  = '{1'b0, 1'b1, 4'd7, 18'h3FFFF, '0,    1'b1, W1234, 1'b0, FF00,  "rd_raw"};
        vecs[5]  = '{1'b1, 1'b1, 4'd0, 18'h3FFFF, '0,    1'b0, W1234, 1'b1, W1234, "idle_a"};
        vecs[6]  = '{1'b1, 1'b1, 4'd0, 18'h3FFFF, '0,    1'b0, W1234, 1'b0, W1234, "idle_b"};
        vecs[7]  = '{1'b0, 1'b0, 4'd7, 18'h3FFFF, '0,    1'b0, W1234, 1'b0, W1234, "wr_noop"};
        vecs[8]  = '{1'b0, 1'b1, 4'd7, 18'h00000, ONES,  1'b1, W1234, 1'b0, W1234, "rd_ign_wen"};
        vecs[9]  = '{1'b1, 1'b0, 4'd8, 18'h00000, ONES,  1'b0, W1234, 1'b1, W1234, "wr_cen_off"};
        vecs[10] = '{1'b0, 1'b1, 4'd8, 18'h3FFFF, '0,    1'b1, IV,    1'b0, W1234, "rd_8"};
        vecs[11] = '{1'b0, 1'b0, 4'd5, 18'h3FFF0, 144'h11223344, 1'b0, IV, 1'b1, IV, "wr_low32"};
        vecs[12] = '{1'b0, 1'b1, 4'd5, 18'h3FFFF, '0,    1'b1, PART,  1'b0, IV,    "rd_5"};
        vecs[13] = '{1'b1, 1'b1, 4'd0, 18'h3FFFF, '0,    1'b0, PART,  1'b1, PART,  "idle_c"};

        // Reset with a simultaneous write that must be discarded.
        rst = 1'b1; cen = 1'b0; gwen = 1'b0; wen = '0; a = 4'd2; d = 144'hDEAD;
        tick();
        chk("rst_q0", bus0.Q, '0);
        chk("rst_vld0", DW'(bus0.Q_VLD), '0);
        chk("rst_busy0", DW'(bus0.INIT_BUSY), DW'(1));
        chk("rst_q1", bus1.Q, '0);
        chk("rst_vld1", DW'(bus1.Q_VLD), '0);

        // Write to addr 2 held during the whole sweep is ignored.
        rst = 1'b0;
        init_wait(n);
        set_idle();
        chk("init_cycles", DW'(n), DW'(16));
        chk("init_done_busy1", DW'(bus1.INIT_BUSY), '0);
        read_sweep();

        for (int i = 0; i < 14; i++) begin
            cen = vecs[i].cen; gwen = vecs[i].gwen; a = vecs[i].a;
            wen = vecs[i].wen; d = vecs[i].d;
            tick();
            chk({vecs[i].name, "_q0"}, bus0.Q, vecs[i].q0);
            chk({vecs[i].name, "_vld0"}, DW'(bus0.Q_VLD), DW'(vecs[i].v0));
            chk({vecs[i].name, "_q1"}, bus1.Q, vecs[i].q1);
            chk({vecs[i].name, "_vld1"}, DW'(bus1.Q_VLD), DW'(vecs[i].v1));
        end

        // Distinct data at addresses 0..3 for the streaming checks.
        for (int j = 0; j < 4; j++) begin
            cen = 1'b0; gwen = 1'b0; wen = '0; a = AW'(j); d = sv(j);
            tick();
        end

        // Back-to-back reads: four consecutive valid cycles, in order.
        for (int j = 0; j <= 4; j++) begin
            if (j < 4) begin
                cen = 1'b0; gwen = 1'b1; a = AW'(j);
            end else begin
                set_idle();
            end
            tick();
            if (j < 4) begin
                chk("strm_q0", bus0.Q, sv(j));
                chk("strm_vld0", DW'(bus0.Q_VLD), DW'(1));
            end else begin
                chk("strm_end_vld0", DW'(bus0.Q_VLD), '0);
            end
            if (j > 0) begin
                chk("strm_q1", bus1.Q, sv(j - 1));
                chk("strm_vld1", DW'(bus1.Q_VLD), DW'(1));
            end
        end
        tick();
        chk("strm_end_vld1", DW'(bus1.Q_VLD), '0);
        chk("strm_hold_q1", bus1.Q, sv(3));

        // Same stream, reset one cycle after the last read drops it.
        for (int j = 0; j <= 4; j++) begin
            if (j < 4) begin
                cen = 1'b0; gwen = 1'b1; a = AW'(j);
            end else begin
                set_idle();
                rst = 1'b1;
            end
            tick();
            if (j < 4) begin
                chk("strm2_q0", bus0.Q, sv(j));
                if (j > 0) chk("strm2_q1", bus1.Q, sv(j - 1));
            end
        end
        chk("drop_vld1", DW'(bus1.Q_VLD), '0);
        chk("drop_q1", bus1.Q, '0);
        chk("drop_vld0", DW'(bus0.Q_VLD), '0);
        chk("drop_q0", bus0.Q, '0);
        chk("drop_busy", DW'(bus0.INIT_BUSY), DW'(1));

        // Reset when icnt reaches 9 restarts the full sweep.
        rst = 1'b0;
        for (int j = 0; j < 9; j++) tick();
        chk("mid_busy", DW'(bus0.INIT_BUSY), DW'(1));
        rst = 1'b1;
        tick();
        chk("mid_rst_busy", DW'(bus1.INIT_BUSY), DW'(1));
        rst = 1'b0;
        init_wait(n);
        chk("reinit_cycles", DW'(n), DW'(16));
        read_sweep();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
